// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4-channel mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, DWELL, OUT} scan_state_t;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic             last;
  } next_ch_t;

  // Next enabled channel strictly above cur; last=1 when none remains.
  function automatic next_ch_t next_enabled(input logic [NCH-1:0] mask,
                                            input logic [SEL_W-1:0] cur);
    next_ch_t r;
    r.ch   = cur;
    r.last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        r.ch   = SEL_W'(i);
        r.last = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] first_enabled(input logic [NCH-1:0] mask);
    next_ch_t n;
    n = next_enabled(mask, '0);
    return mask[0] ? '0 : n.ch;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Control, mux and snapshot handshake signals of the scan sequencer.
interface mux4_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
);
  logic               start;
  logic [NCH-1:0]     mask;
  logic [DWELL_W-1:0] dwell;
  logic               continuous;
  logic [SEL_W-1:0]   sel;
  logic               q;
  logic [NCH-1:0]     snap;
  logic               snap_valid;
  logic               snap_ready;
  logic               busy;

  modport master (
    input  start, mask, dwell, continuous, q, snap_ready,
    output sel, snap, snap_valid, busy
  );

  modport slave (
    output start, mask, dwell, continuous, q, snap_ready,
    input  sel, snap, snap_valid, busy
  );
endinterface

// File: rtl/scan_dwell_cnt.sv
// Per-channel dwell down-counter; zero flags the last cycle of a dwell.
module scan_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  input  logic               dec,
  output logic               zero
);
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = value;
    else if (dec) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans enabled mux channels with a programmable dwell and presents the
// sampled 4-bit snapshot on a valid/ready output.
module mux4_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux4_scan_ctrl_if.master  bus
);
  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [NCH-1:0]     acc_q, acc_d;
  logic [NCH-1:0]     snap_q, snap_d;
  logic               snap_valid_q, snap_valid_d;
  logic               busy_q, busy_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_value;
  next_ch_t           nxt;

  scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    reload_d  = reload_q;
    acc_d     = acc_q;
    snap_d    = snap_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = reload_q;
    nxt       = next_enabled(mask_q, sel_q);

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.mask != '0)) begin
          state_d   = DWELL;
          mask_d    = bus.mask;
          // Reload value stored as D-1 so a zero dwell behaves as one cycle.
          reload_d  = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
          sel_d     = first_enabled(bus.mask);
          acc_d     = '0;
          cnt_load  = 1'b1;
          cnt_value = reload_d;
        end
      end
      DWELL: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          acc_d[sel_q] = bus.q;
          if (!nxt.last) begin
            sel_d    = nxt.ch;
            cnt_load = 1'b1;
          end else begin
            snap_d  = acc_d;
            sel_d   = '0;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.snap_ready) begin
          if (bus.continuous) begin
            state_d  = DWELL;
            sel_d    = first_enabled(mask_q);
            acc_d    = '0;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    snap_valid_d = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      reload_q     <= '0;
      acc_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      reload_q     <= reload_d;
      acc_q        <= acc_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.snap       = snap_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: table vectors, random scans against
// a scan-level model, and hand-written backpressure/continuous/reset sequences.
module tb_mux4_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mux_in = 4'b0000;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0] obs_sel[$];
  logic [1:0] exp_sel[$];
  int         timed_out;

  mux4_scan_ctrl_if #(.DWELL_W(8)) bus ();

  mux4_scan_ctrl #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.q = mux_in[bus.sel];

  typedef struct {
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [3:0] din;
    logic [3:0] exp_snap;
    int         exp_cyc;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected select sequence: each enabled channel in ascending order, D times.
  task automatic model_seq(input logic [3:0] mask, input logic [7:0] dwell);
    int d;
    d = (dwell == 0) ? 1 : int'(dwell);
    exp_sel.delete();
    for (int ch = 0; ch < 4; ch++)
      if (mask[ch])
        for (int k = 0; k < d; k++) exp_sel.push_back(2'(ch));
  endtask

  // From the first cycle of a scan, record sel until snap_valid appears.
  task automatic collect();
    obs_sel.delete();
    timed_out = 1;
    for (int n = 0; n < 3000; n++) begin
      if (bus.snap_valid) begin
        timed_out = 0;
        break;
      end
      obs_sel.push_back(bus.sel);
      tick();
    end
  endtask

  task automatic compare_seq(input string name);
    int bad;
    bad = -1;
    check({name, "_len"}, obs_sel.size(), exp_sel.size());
    for (int i = 0; i < obs_sel.size() && i < exp_sel.size(); i++)
      if (bad < 0 && obs_sel[i] != exp_sel[i]) bad = i;
    check({name, "_sel_first_bad_idx"}, bad, -1);
  endtask

  task automatic run_scan(input string name, input logic [3:0] mask,
                          input logic [7:0] dwell, input logic [3:0] din,
                          input logic [3:0] exp_snap, input int exp_cyc);
    mux_in    = din;
    bus.mask  = mask;
    bus.dwell = dwell;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mask  = 4'($urandom);
    bus.dwell = 8'($urandom);
    check({name, "_busy_rise"}, int'(bus.busy), 1);
    collect();
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_cycles"}, obs_sel.size(), exp_cyc);
    model_seq(mask, dwell);
    compare_seq(name);
    check({name, "_snap"}, int'(bus.snap), int'(exp_snap));
    tick();
    check({name, "_valid_drop"}, int'(bus.snap_valid), 0);
    check({name, "_busy_drop"}, int'(bus.busy), 0);
    check({name, "_snap_hold"}, int'(bus.snap), int'(exp_snap));
  endtask

  initial begin
    logic [3:0] m, din;
    logic [7:0] dw;
    int         any;
    int         pc;

    vt[0] = '{mask: 4'b1111, dwell: 8'd2, din: 4'b1010, exp_snap: 4'b1010, exp_cyc: 8};
    vt[1] = '{mask: 4'b0101, dwell: 8'd3, din: 4'b1111, exp_snap: 4'b0101, exp_cyc: 6};
    vt[2] = '{mask: 4'b1111, dwell: 8'd0, din: 4'b0110, exp_snap: 4'b0110, exp_cyc: 4};
    vt[3] = '{mask: 4'b1000, dwell: 8'd1, din: 4'b1000, exp_snap: 4'b1000, exp_cyc: 1};
    vt[4] = '{mask: 4'b0010, dwell: 8'd5, din: 4'b1101, exp_snap: 4'b0000, exp_cyc: 5};
    vt[5] = '{mask: 4'b1011, dwell: 8'd1, din: 4'b1011, exp_snap: 4'b1011, exp_cyc: 3};

    bus.start      = 1'b0;
    bus.mask       = 4'b0000;
    bus.dwell      = 8'd0;
    bus.continuous = 1'b0;
    bus.snap_ready = 1'b1;
    rst            = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_sel", int'(bus.sel), 0);
    check("rst_snap", int'(bus.snap), 0);
    check("rst_valid", int'(bus.snap_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    tick();

    for (int i = 0; i < 6; i++)
      run_scan($sformatf("vec%0d", i), vt[i].mask, vt[i].dwell, vt[i].din,
               vt[i].exp_snap, vt[i].exp_cyc);

    // start with an empty mask must not leave IDLE
    bus.mask  = 4'b0000;
    bus.dwell = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    any = 0;
    for (int i = 0; i < 5; i++) begin
      any |= int'(bus.busy) | int'(bus.snap_valid);
      tick();
    end
    check("empty_mask_idle", any, 0);

    // Backpressure: snapshot stays put, start ignored, transfer on ready
    bus.snap_ready = 1'b0;
    mux_in    = 4'b0110;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    collect();
    check("bp_timeout", timed_out, 0);
    check("bp_cycles", obs_sel.size(), 4);
    check("bp_snap", int'(bus.snap), 4'b0110);
    any = 0;
    for (int i = 0; i < 5; i++) begin
      mux_in    = 4'($urandom);
      bus.start = (i == 2);
      tick();
      if (!bus.snap_valid || bus.snap != 4'b0110 || bus.sel != 2'd0 || !bus.busy) any++;
    end
    bus.start = 1'b0;
    check("bp_hold_bad_cycles", any, 0);
    bus.snap_ready = 1'b1;
    tick();
    check("bp_valid_drop", int'(bus.snap_valid), 0);
    check("bp_busy_drop", int'(bus.busy), 0);

    // Continuous mode: back-to-back scans, no idle cycle
    bus.continuous = 1'b1;
    mux_in    = 4'b0011;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    collect();
    check("cont1_timeout", timed_out, 0);
    check("cont1_cycles", obs_sel.size(), 4);
    check("cont1_snap", int'(bus.snap), 4'b0011);
    mux_in = 4'b1100;
    tick();
    check("cont_valid_drop", int'(bus.snap_valid), 0);
    check("cont_busy", int'(bus.busy), 1);
    check("cont_sel_first", int'(bus.sel), 0);
    collect();
    check("cont2_timeout", timed_out, 0);
    model_seq(4'b1111, 8'd1);
    compare_seq("cont2");
    check("cont2_snap", int'(bus.snap), 4'b1100);
    bus.continuous = 1'b0;
    tick();
    check("cont_end_busy", int'(bus.busy), 0);

    // Reset during channel 2 dwell aborts the scan
    mux_in    = 4'b1111;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pc = 0;
    while (bus.sel != 2'd2 && pc < 50) begin
      tick();
      pc++;
    end
    check("rst_mid_reached_ch2", pc, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_sel", int'(bus.sel), 0);
    check("rst_mid_snap", int'(bus.snap), 0);
    check("rst_mid_valid", int'(bus.snap_valid), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    any = 0;
    for (int i = 0; i < 12; i++) begin
      any |= int'(bus.snap_valid) | int'(bus.busy);
      tick();
    end
    check("rst_mid_no_valid", any, 0);
    run_scan("post_rst", 4'b1111, 8'd2, 4'b1001, 4'b1001, 8);

    // Random scans against the scan-level model
    for (int r = 0; r < 25; r++) begin
      m   = 4'($urandom_range(1, 15));
      dw  = 8'($urandom_range(0, 6));
      din = 4'($urandom);
      pc  = $countones(m) * ((dw == 0) ? 1 : int'(dw));
      run_scan($sformatf("rnd%0d", r), m, dw, din, din & m, pc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
